// File: rtl/alu_fun_dispatch.sv
// alu_fun_dispatch
//   Registered ALU function dispatcher. It accepts a function code over a
//   valid/ready handshake and splits it into a unit select (MSBs) and a
//   sub-function (LSBs). It then holds a one-hot enable on the selected
//   execution unit until that unit reports done. It also reports illegal
//   selects, pulses a completion flag and counts completed operations.
//
//   Optional build macro: ALU_DISPATCH_TIMEOUT_EN
//     When defined, a watchdog aborts an operation after TIMEOUT cycles in
//     RUN without a done from the selected unit (err pulse, no out_valid).
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   fun_in        in   [FUN_W]          function code {sel, sub}
//   fun_valid     in   fun_in valid
//   fun_ready     out  dispatcher can accept a code (IDLE)
//   unit_en       out  [NUM_UNITS]      registered one-hot unit enable
//   unit_sub_fun  out  [FUN_W-SEL_W]    captured sub-function
//   unit_done     in   [NUM_UNITS]      per-unit completion strobes
//   out_valid     out  one-cycle completion pulse
//   out_unit      out  [SEL_W]          index of the last completed unit
//   busy          out  operation in flight (RUN)
//   err           out  one-cycle pulse: illegal select or timeout
//   done_cnt      out  [CNT_W]          completed-operation count, wraps
module alu_fun_dispatch #(
   parameter int FUN_W     = 4,
   parameter int SEL_W     = 2,
   parameter int NUM_UNITS = 4,
   parameter int CNT_W     = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FUN_W-1:0]       fun_in,
   input  logic                   fun_valid,
   output logic                   fun_ready,
   output logic [NUM_UNITS-1:0]   unit_en,
   output logic [FUN_W-SEL_W-1:0] unit_sub_fun,
   input  logic [NUM_UNITS-1:0]   unit_done,
   output logic                   out_valid,
   output logic [SEL_W-1:0]       out_unit,
   output logic                   busy,
   output logic                   err,
   output logic [CNT_W-1:0]       done_cnt
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t                 r_state, w_state_nxt;
   logic [NUM_UNITS-1:0]   r_unit_en;
   logic [FUN_W-SEL_W-1:0] r_sub;
   logic [SEL_W-1:0]       r_sel;
   logic                   r_out_valid;
   logic [SEL_W-1:0]       r_out_unit;
   logic                   r_err;
   logic [CNT_W-1:0]       r_cnt;

   logic [SEL_W-1:0]       w_sel;
   logic [FUN_W-SEL_W-1:0] w_sub;
   logic                   w_sel_legal;
   logic [NUM_UNITS-1:0]   w_sel_oh;
   logic                   w_done;
   logic                   w_accept, w_illegal, w_complete, w_abort;

   assign w_sel       = fun_in[FUN_W-1 -: SEL_W];
   assign w_sub       = fun_in[FUN_W-SEL_W-1:0];
   assign w_sel_legal = (32'(w_sel) < NUM_UNITS);

   always_comb begin
      w_sel_oh = '0;
      for (int i = 0; i < NUM_UNITS; i++) w_sel_oh[i] = (32'(w_sel) == i);
   end

   // The enable register is one-hot on the captured select while in RUN.
   // Masking with it picks out unit_done[sel] and ignores other units.
   assign w_done = |(unit_done & r_unit_en);

`ifdef ALU_DISPATCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_tcnt;
   logic          w_tmo;

   // r_tcnt holds the number of RUN cycles already completed. Abort at the
   // edge that ends the TIMEOUT-th RUN cycle.
   assign w_tmo = (r_tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || w_accept) r_tcnt <= '0;
      else if (r_state == S_RUN) r_tcnt <= r_tcnt + TW'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_illegal   = 1'b0;
      w_complete  = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (fun_valid) begin
               if (w_sel_legal) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_RUN;
               end else begin
                  w_illegal   = 1'b1;   // code consumed, stay in IDLE
               end
            end
         end
         S_RUN: begin
            // done takes priority over a coincident timeout
            if (w_done) begin
               w_complete  = 1'b1;
               w_state_nxt = S_IDLE;
            end
`ifdef ALU_DISPATCH_TIMEOUT_EN
            else if (w_tmo) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_unit_en   <= '0;
         r_sub       <= '0;
         r_sel       <= '0;
         r_out_valid <= 1'b0;
         r_out_unit  <= '0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_out_valid <= w_complete;
         r_err       <= w_illegal | w_abort;
         if (w_accept) begin
            r_unit_en <= w_sel_oh;
            r_sub     <= w_sub;
            r_sel     <= w_sel;
         end else if (w_complete || w_abort) begin
            r_unit_en <= '0;
         end
         if (w_complete) begin
            r_out_unit <= r_sel;
            r_cnt      <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign fun_ready    = (r_state == S_IDLE);
   assign busy         = (r_state == S_RUN);
   assign unit_en      = r_unit_en;
   assign unit_sub_fun = r_sub;
   assign out_valid    = r_out_valid;
   assign out_unit     = r_out_unit;
   assign err          = r_err;
   assign done_cnt     = r_cnt;

endmodule

// File: tb/tb_alu_fun_dispatch.sv
// Testbench for alu_fun_dispatch.
//   Instance a: default parameters (4 units, 8-bit counter).
//   Instance b: NUM_UNITS=3, CNT_W=2 for illegal-select and counter wrap.
//   A transaction-level model tracks instance a on every clock edge.
module tb_alu_fun_dispatch;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] fun_in;
   logic       fun_valid;
   logic [3:0] unit_done;
   logic       fun_ready, out_valid, busy, err;
   logic [3:0] unit_en;
   logic [1:0] unit_sub_fun, out_unit;
   logic [7:0] done_cnt;

   logic [3:0] b_fun_in;
   logic       b_fun_valid;
   logic [2:0] b_unit_done;
   logic       b_fun_ready, b_out_valid, b_busy, b_err;
   logic [2:0] b_unit_en;
   logic [1:0] b_unit_sub_fun, b_out_unit;
   logic [1:0] b_done_cnt;

   int n_vec = 0;
   int n_err = 0;

   // reference model state for instance a
   bit       m_busy;
   int       m_sel, m_sub, m_unit, m_age;
   bit       m_ov, m_err;
   int       m_cnt;

   always #5 clk = ~clk;

   alu_fun_dispatch u_a (
      .clk(clk), .rst(rst), .fun_in(fun_in), .fun_valid(fun_valid),
      .fun_ready(fun_ready), .unit_en(unit_en), .unit_sub_fun(unit_sub_fun),
      .unit_done(unit_done), .out_valid(out_valid), .out_unit(out_unit),
      .busy(busy), .err(err), .done_cnt(done_cnt));

   alu_fun_dispatch #(.NUM_UNITS(3), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .fun_in(b_fun_in), .fun_valid(b_fun_valid),
      .fun_ready(b_fun_ready), .unit_en(b_unit_en), .unit_sub_fun(b_unit_sub_fun),
      .unit_done(b_unit_done), .out_valid(b_out_valid), .out_unit(b_out_unit),
      .busy(b_busy), .err(b_err), .done_cnt(b_done_cnt));

   // Advance the model by one edge using the current inputs of instance a,
   // then clock the DUTs and step to a sampling point away from the edge.
   task automatic tick();
      int sel;
      if (rst) begin
         m_busy = 0; m_sel = 0; m_sub = 0; m_unit = 0; m_age = 0;
         m_ov = 0; m_err = 0; m_cnt = 0;
      end else begin
         m_ov = 0; m_err = 0;
         if (!m_busy) begin
            if (fun_valid) begin
               sel = int'(fun_in) / 4;
               if (sel < 4) begin
                  m_busy = 1; m_sel = sel; m_sub = int'(fun_in) % 4; m_age = 0;
               end else m_err = 1;
            end
         end else if (unit_done[m_sel]) begin
            m_busy = 0; m_ov = 1; m_unit = m_sel; m_cnt = (m_cnt + 1) % 256;
         end else begin
            m_age++;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            if (m_age >= 15) begin m_busy = 0; m_err = 1; end
`endif
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fun_valid = 0; fun_in = 0; unit_done = 0;
      b_fun_valid = 0; b_fun_in = 0; b_unit_done = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; tick(); rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1; fun_valid = 1; fun_in = 4'b0100; tick(); tick();
      rst = 0; fun_valid = 0;
      n_vec++;
      if (fun_ready !== 1'b1 || unit_en !== 4'b0 || unit_sub_fun !== 2'b0 ||
          out_valid !== 1'b0 || out_unit !== 2'b0 || busy !== 1'b0 ||
          err !== 1'b0 || done_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL reset_a: rdy=%b en=%b sub=%b ov=%b ou=%0d busy=%b err=%b cnt=%0d required 1 0000 00 0 0 0 0 0",
                  fun_ready, unit_en, unit_sub_fun, out_valid, out_unit, busy, err, done_cnt);
      end
      n_vec++;
      if (b_fun_ready !== 1'b1 || b_unit_en !== 3'b0 || b_busy !== 1'b0 || b_done_cnt !== 2'd0) begin
         n_err++;
         $display("FAIL reset_b: rdy=%b en=%b busy=%b cnt=%0d required 1 000 0 0",
                  b_fun_ready, b_unit_en, b_busy, b_done_cnt);
      end
   endtask

   task automatic test_single();
      do_reset();
      fun_in = 4'b1001; fun_valid = 1; tick();
      fun_valid = 0; fun_in = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         n_vec++;
         if (unit_en !== 4'b0100 || unit_sub_fun !== 2'b01 || busy !== 1'b1 ||
             fun_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_hold[%0d]: en=%b sub=%b busy=%b rdy=%b ov=%b required 0100 01 1 0 0",
                     c, unit_en, unit_sub_fun, busy, fun_ready, out_valid);
         end
         if (c < 2) tick();
      end
      unit_done = 4'b0100; tick(); unit_done = 0;
      n_vec++;
      if (out_valid !== 1'b1 || out_unit !== 2'd2 || done_cnt !== 8'd1 ||
          unit_en !== 4'b0 || busy !== 1'b0 || fun_ready !== 1'b1) begin
         n_err++;
         $display("FAIL single_done: ov=%b ou=%0d cnt=%0d en=%b busy=%b rdy=%b required 1 2 1 0000 0 1",
                  out_valid, out_unit, done_cnt, unit_en, busy, fun_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || out_unit !== 2'd2 || done_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL single_after: ov=%b ou=%0d cnt=%0d required 0 2 1", out_valid, out_unit, done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fun_in = 4'b0000; fun_valid = 1; tick();
      n_vec++;
      if (unit_en !== 4'b0001) begin
         n_err++; $display("FAIL b2b_en0: en=%b required 0001", unit_en);
      end
      fun_valid = 0; unit_done = 4'b0001; tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_unit !== 2'd0 || fun_ready !== 1'b1 || unit_en !== 4'b0) begin
         n_err++;
         $display("FAIL b2b_done0: ov=%b ou=%0d rdy=%b en=%b required 1 0 1 0000", out_valid, out_unit, fun_ready, unit_en);
      end
      // done from unit 3 in the acceptance cycle itself must not complete the op
      fun_in = 4'b1100; fun_valid = 1; unit_done = 4'b1000; tick();
      n_vec++;
      if (unit_en !== 4'b1000 || busy !== 1'b1 || out_valid !== 1'b0 || done_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL b2b_en1: en=%b busy=%b ov=%b cnt=%0d required 1000 1 0 1", unit_en, busy, out_valid, done_cnt);
      end
      fun_valid = 0; unit_done = 4'b1000; tick(); unit_done = 0;
      n_vec++;
      if (out_valid !== 1'b1 || out_unit !== 2'd3 || done_cnt !== 8'd2 || unit_en !== 4'b0) begin
         n_err++;
         $display("FAIL b2b_done1: ov=%b ou=%0d cnt=%0d en=%b required 1 3 2 0000", out_valid, out_unit, done_cnt, unit_en);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      b_fun_in = 4'b1110; b_fun_valid = 1; tick(); b_fun_valid = 0;
      n_vec++;
      if (b_err !== 1'b1 || b_unit_en !== 3'b0 || b_out_valid !== 1'b0 || b_fun_ready !== 1'b1 || b_busy !== 1'b0) begin
         n_err++;
         $display("FAIL illegal_pulse: err=%b en=%b ov=%b rdy=%b busy=%b required 1 000 0 1 0",
                  b_err, b_unit_en, b_out_valid, b_fun_ready, b_busy);
      end
      tick();
      n_vec++;
      if (b_err !== 1'b0 || b_unit_en !== 3'b0 || b_out_valid !== 1'b0 || b_done_cnt !== 2'd0) begin
         n_err++;
         $display("FAIL illegal_after: err=%b en=%b ov=%b cnt=%0d required 0 000 0 0", b_err, b_unit_en, b_out_valid, b_done_cnt);
      end
   endtask

   task automatic test_wrong_done_reset();
      do_reset();
      fun_in = 4'b1000; fun_valid = 1; tick(); fun_valid = 0;
      unit_done = 4'b0001; tick(); unit_done = 0;
      n_vec++;
      if (unit_en !== 4'b0100 || busy !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL wrong_done: en=%b busy=%b ov=%b required 0100 1 0", unit_en, busy, out_valid);
      end
      // reset together with the right done: reset must win
      rst = 1; unit_done = 4'b0100; tick(); rst = 0; unit_done = 0;
      n_vec++;
      if (unit_en !== 4'b0 || busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 || done_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL mid_reset: en=%b busy=%b ov=%b err=%b cnt=%0d required 0000 0 0 0 0", unit_en, busy, out_valid, err, done_cnt);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || err !== 1'b0 || fun_ready !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset: ov=%b err=%b rdy=%b required 0 0 1", out_valid, err, fun_ready);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         b_fun_in = 4'((k % 3) * 4 + 1); b_fun_valid = 1; tick(); b_fun_valid = 0;
         b_unit_done = 3'b001 << (k % 3); tick(); b_unit_done = 0;
         if (k == 3) begin
            n_vec++;
            if (b_done_cnt !== 2'd0) begin
               n_err++; $display("FAIL wrap4: cnt=%0d required 0", b_done_cnt);
            end
         end
      end
      n_vec++;
      if (b_done_cnt !== 2'd1 || b_out_valid !== 1'b1 || b_out_unit !== 2'd1) begin
         n_err++;
         $display("FAIL wrap5: cnt=%0d ov=%b ou=%0d required 1 1 1", b_done_cnt, b_out_valid, b_out_unit);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      fun_in = 4'b0110; fun_valid = 1; tick(); fun_valid = 0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      for (int c = 1; c < 15; c++) tick();
      n_vec++;
      if (busy !== 1'b1 || unit_en !== 4'b0010 || err !== 1'b0) begin
         n_err++; $display("FAIL tmo_before: busy=%b en=%b err=%b required 1 0010 0", busy, unit_en, err);
      end
      tick();
      n_vec++;
      if (err !== 1'b1 || unit_en !== 4'b0 || busy !== 1'b0 || out_valid !== 1'b0 || done_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL tmo_abort: err=%b en=%b busy=%b ov=%b cnt=%0d required 1 0000 0 0 0", err, unit_en, busy, out_valid, done_cnt);
      end
      tick();
      n_vec++;
      if (err !== 1'b0) begin
         n_err++; $display("FAIL tmo_pulse: err=%b required 0", err);
      end
      // done arriving on the timeout edge wins
      fun_in = 4'b0110; fun_valid = 1; tick(); fun_valid = 0;
      for (int c = 1; c < 15; c++) tick();
      unit_done = 4'b0010; tick(); unit_done = 0;
      n_vec++;
      if (out_valid !== 1'b1 || err !== 1'b0 || done_cnt !== 8'd1) begin
         n_err++; $display("FAIL tmo_done_wins: ov=%b err=%b cnt=%0d required 1 0 1", out_valid, err, done_cnt);
      end
`else
      for (int c = 0; c < 40; c++) tick();
      n_vec++;
      if (busy !== 1'b1 || unit_en !== 4'b0010 || err !== 1'b0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL no_tmo_wait: busy=%b en=%b err=%b ov=%b required 1 0010 0 0", busy, unit_en, err, out_valid);
      end
      unit_done = 4'b0010; tick(); unit_done = 0;
`endif
   endtask

   task automatic test_random();
      logic [3:0] exp_en;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 63) == 0);
         fun_valid = ($urandom_range(0, 2) != 0);
         fun_in    = 4'($urandom);
         unit_done = 4'($urandom) & 4'($urandom);
         tick();
         exp_en = m_busy ? (4'b0001 << m_sel) : 4'b0000;
         n_vec++;
         if (unit_en !== exp_en || busy !== m_busy || fun_ready !== !m_busy ||
             out_valid !== m_ov || err !== m_err || done_cnt !== 8'(m_cnt) ||
             out_unit !== 2'(m_unit) || (m_busy && unit_sub_fun !== 2'(m_sub))) begin
            n_err++;
            $display("FAIL random[%0d]: en=%b busy=%b ov=%b err=%b cnt=%0d ou=%0d sub=%b required en=%b busy=%b ov=%b err=%b cnt=%0d ou=%0d sub=%0d",
                     c, unit_en, busy, out_valid, err, done_cnt, out_unit, unit_sub_fun,
                     exp_en, m_busy, m_ov, m_err, m_cnt, m_unit, m_sub);
         end
      end
      rst = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_single();
      test_back_to_back();
      test_illegal();
      test_wrong_done_reset();
      test_wrap();
      test_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_fun_dispatch.md
Name: alu_fun_dispatch

Overview:
- Parametrised, registered successor to the combinational ALU function decoder.
- Accepts an ALU function code over a valid/ready handshake and splits it into a unit-select field and a sub-function field.
- Drives a one-hot enable to NUM_UNITS execution units and holds that enable until the selected unit reports done.
- Sits between the system controller and the ALU unit bank (arith/logic/cmp/shift/...); adds busy tracking, completion pulses, illegal-select detection and a completion counter.

Parameters:
- FUN_W, 4, total width of the function code.
- SEL_W, 2, unit-select width; taken from the MSBs of the function code.
- NUM_UNITS, 4, number of units, 1..2**SEL_W; select values >= NUM_UNITS are illegal.
- CNT_W, 8, width of the completed-operation counter.
- TIMEOUT, 15, watchdog limit in cycles (used only when the optional feature is compiled in).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fun_in  in  FUN_W  function code; sel = fun_in[FUN_W-1 -: SEL_W], sub = remaining LSBs.
- fun_valid  in  1  fun_in is valid.
- fun_ready  out  1  dispatcher can accept a code.
- unit_en  out  NUM_UNITS  one-hot unit enable (registered).
- unit_sub_fun  out  FUN_W-SEL_W  captured sub-function, held while unit_en is active.
- unit_done  in  NUM_UNITS  per-unit completion strobe.
- out_valid  out  1  one-cycle pulse when the operation completes.
- out_unit  out  SEL_W  index of the unit that completed; valid with out_valid, held until the next completion.
- busy  out  1  an operation is in flight.
- err  out  1  one-cycle pulse on an illegal select or a timeout.
- done_cnt  out  CNT_W  count of completed operations, wraps modulo 2**CNT_W.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE, fun_ready=1, unit_en=0, unit_sub_fun=0, out_valid=0, out_unit=0, busy=0, err=0, done_cnt=0. Reset overrides every other event in the same cycle.
- Reset mid-operation: unit_en drops at that edge, the in-flight op is discarded, and neither out_valid nor err is produced for it.
- FSM states: IDLE, RUN.
- IDLE:
  - fun_ready=1, busy=0.
  - Acceptance happens at an edge where fun_valid=1.
  - Legal sel: capture sel and sub; at that edge unit_en becomes one-hot at bit sel, unit_sub_fun=sub, busy=1, fun_ready=0; go to RUN.
  - Illegal sel (sel >= NUM_UNITS): code is consumed, err pulses for the next cycle, unit_en stays 0, no out_valid; remain in IDLE.
- RUN:
  - unit_en and unit_sub_fun are held stable.
  - fun_valid is ignored (fun_ready=0).
  - At an edge where unit_done[sel]=1: unit_en=0, busy=0, out_valid=1 for one cycle, out_unit=sel, done_cnt+1; go to IDLE.
- Done strobes from unselected units, and any unit_done while in IDLE, are ignored.
- Done is sampled only from the edge after acceptance: a done strobe present in the acceptance cycle itself does not complete the op.
- Minimum latency: accept at edge N; done can be sampled at N+1; out_valid is high in cycle N+1..N+2.
- Maximum throughput: one op every 2 cycles. fun_ready is high in the same cycle as out_valid, so back-to-back acceptance is allowed.
- done_cnt wraps from 2**CNT_W-1 to 0 with no flag.
- unit_en is never multi-hot; at most one bit is set in any cycle.

Optional Feature:
- Macro: ALU_DISPATCH_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter clears on acceptance and increments each RUN cycle.
  - If it reaches TIMEOUT without unit_done[sel], the op is aborted: unit_en=0, err pulses one cycle, no out_valid, done_cnt unchanged; go to IDLE.
  - If done arrives at the same edge the counter reaches TIMEOUT, done wins.
- Without the macro: no counter; RUN waits indefinitely.

Test Plan:
- Reset then idle -> all outputs at reset values; fun_ready=1; done_cnt=0.
- fun_in=4'b1001, valid for 1 cycle, unit_done=4'b0100 three cycles later -> unit_en=4'b0100 and unit_sub_fun=2'b01 for 3 cycles, then out_valid pulse with out_unit=2, done_cnt=1.
- Back-to-back codes 4'b0000 then 4'b1100, with done asserted one cycle after each accept -> two ops, each 2 cycles; unit_en sequence 0001 then 1000; done_cnt=2.
- NUM_UNITS=3, fun_in=4'b1110 -> err pulses once; unit_en stays 0; no out_valid; fun_ready stays 1.
- unit_done=4'b0001 while unit 2 is selected, then rst=1 mid-RUN -> wrong done ignored; reset clears unit_en next edge; no out_valid.
- ALU_DISPATCH_TIMEOUT_EN defined, TIMEOUT=15, no done -> err after 15 RUN cycles, unit_en=0, done_cnt unchanged. CNT_W=2 with 5 ops -> done_cnt=1 (wrap).
